shift_cmd_sequencer: RTL

SHIFT_CMD_SEQUENCER -- requirements
Module: shift_cmd_sequencer

---
 rtl/shift_cmd_sequencer.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/shift_cmd_sequencer.sv
// Command-driven serializer for a downstream shift register.
// Commands {count, dir, data} queue in a small FIFO; the FSM pops one at a
// time and emits count single-bit shifts, sending data LSB first.
// Handshake: a command transfers on a rising clk edge where cmd_valid and
// cmd_ready are both 1; cmd_ready depends on registered state only, and
// cmd_valid may be held while cmd_ready is 0 without any effect.
module shift_cmd_sequencer #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     flush,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic [3:0]               cmd_count,
    input  logic                     cmd_dir,
    input  logic [14:0]              cmd_data,
    output logic [3:0]               sr_shift_count,
    output logic                     sr_dir,
    output logic                     sr_serial_in,
    output logic                     busy,
    output logic                     done,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]   LVL_FULL = (AW+1)'(DEPTH);
    localparam logic [AW:0]   LVL_ZERO = '0;
    localparam logic [AW:0]   LVL_ONE  = (AW+1)'(1);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SHIFT = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // FIFO storage and pointers
    logic [19:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [19:0]   head;
    logic          push;
    logic          pop;

    // FSM state and current command
    state_t        state;
    state_t        state_n;
    logic [3:0]    cur_count;
    logic          cur_dir;
    logic [14:0]   cur_data;
    logic [15:0]   data_ext;
    logic [3:0]    idx;
    logic [3:0]    idx_n;
    logic [3:0]    remaining;
    logic [3:0]    remaining_n;

    // Next values of the registered outputs
    logic [3:0]    shift_count_d;
    logic          dir_d;
    logic          serial_d;
    logic          busy_d;
    logic          done_d;

    assign cmd_ready = (level != LVL_FULL);
    assign push      = cmd_valid && cmd_ready && !flush;
    assign head      = mem[rd_ptr];
    // Extra zero bit keeps the index in range when idx reaches 15.
    assign data_ext  = {1'b0, cur_data};

    // FIFO storage write; contents need no reset since level gates reads
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {cmd_count, cmd_dir, cmd_data};
        end
    end

    // FIFO pointers and occupancy; flush empties the queue
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
            case ({push, pop})
                2'b10:   level <= level + LVL_ONE;
                2'b01:   level <= level - LVL_ONE;
                default: level <= level;
            endcase
        end
    end

    // FSM state register plus command and progress registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            idx       <= '0;
            remaining <= '0;
            cur_count <= '0;
            cur_dir   <= 1'b0;
            cur_data  <= '0;
        end else begin
            state     <= state_n;
            idx       <= idx_n;
            remaining <= remaining_n;
            if (pop) begin
                {cur_count, cur_dir, cur_data} <= head;
            end
        end
    end

    // Next-state logic; flush overrides every transition and the pop
    always_comb begin
        state_n     = state;
        idx_n       = idx;
        remaining_n = remaining;
        pop         = 1'b0;
        case (state)
            ST_IDLE: begin
                if (level != LVL_ZERO) begin
                    pop     = 1'b1;
                    state_n = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (cur_count == 4'd0) begin
                    state_n = ST_DONE;
                end else begin
                    remaining_n = cur_count;
                    idx_n       = 4'd0;
                    state_n     = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                idx_n       = idx + 4'd1;
                remaining_n = remaining - 4'd1;
                if (remaining == 4'd1) state_n = ST_DONE;
            end
            ST_DONE: begin
                state_n = ST_IDLE;
            end
            default: state_n = ST_IDLE;
        endcase
        if (flush) begin
            state_n     = ST_IDLE;
            pop         = 1'b0;
            idx_n       = 4'd0;
            remaining_n = 4'd0;
        end
    end

    // Output decode from the upcoming state so the registered outputs line up with it
    always_comb begin
        shift_count_d = 4'd0;
        dir_d         = 1'b0;
        serial_d      = 1'b0;
        busy_d        = (state_n != ST_IDLE);
        done_d        = (state_n == ST_DONE);
        if (state_n == ST_SHIFT) begin
            shift_count_d = 4'd1;
            dir_d         = cur_dir;
            serial_d      = data_ext[idx_n];
        end
    end

    // Output registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sr_shift_count <= '0;
            sr_dir         <= 1'b0;
            sr_serial_in   <= 1'b0;
            busy           <= 1'b0;
            done           <= 1'b0;
        end else begin
            sr_shift_count <= shift_count_d;
            sr_dir         <= dir_d;
            sr_serial_in   <= serial_d;
            busy           <= busy_d;
            done           <= done_d;
        end
    end

endmodule
